// File: rtl/iob_mem_arb_wrapper.sv
// iob_mem_arb_wrapper
// Lets N_CH IOb native slave channels share one single-port, byte-enabled
// synchronous RAM. A round-robin arbiter grants at most one request per cycle
// and drives the RAM in the same cycle. Read completions are routed back to
// the issuing channel by a RAM_LAT-deep pipeline of channel tags.
//
// Ports
//   clk_i         clock, rising edge
//   arst_i        synchronous active-high reset
//   iob_valid_i   per-channel request valid
//   iob_addr_i    per-channel byte address (slice k = channel k)
//   iob_wdata_i   per-channel write data
//   iob_wstrb_i   per-channel byte strobes, all zeros = read
//   iob_ready_o   one-hot grant, combinational
//   iob_rvalid_o  per-channel read data valid
//   iob_rdata_o   per-channel read data, zero unless rvalid for that slice
//   ram_en_o      RAM access enable
//   ram_we_o      RAM byte write enables
//   ram_addr_o    RAM word address
//   ram_d_o       RAM write data
//   ram_d_i       RAM read data, RAM_LAT cycles after ram_en_o
module iob_mem_arb_wrapper #(
  parameter int N_CH    = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 17,
  parameter int RAM_LAT = 1,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF_W  = $clog2(STRB_W),
  localparam int RAM_AW = ADDR_W - OFF_W
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic [N_CH-1:0]          iob_valid_i,
  input  logic [N_CH*ADDR_W-1:0]   iob_addr_i,
  input  logic [N_CH*DATA_W-1:0]   iob_wdata_i,
  input  logic [N_CH*STRB_W-1:0]   iob_wstrb_i,
  output logic [N_CH-1:0]          iob_ready_o,
  output logic [N_CH-1:0]          iob_rvalid_o,
  output logic [N_CH*DATA_W-1:0]   iob_rdata_o,
  output logic                     ram_en_o,
  output logic [STRB_W-1:0]        ram_we_o,
  output logic [RAM_AW-1:0]        ram_addr_o,
  output logic [DATA_W-1:0]        ram_d_o,
  input  logic [DATA_W-1:0]        ram_d_i
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  gnt_ch;
  logic              gnt;
  logic              gnt_rd;
  // Holds off grants for the cycle right after a reset edge.
  logic              blk_q;
  logic [ADDR_W-1:0] addr_g;
  logic [DATA_W-1:0] wdata_g;
  logic [STRB_W-1:0] wstrb_g;

  logic              tag_v  [RAM_LAT];
  logic [PTR_W-1:0]  tag_ch [RAM_LAT];

  // First valid channel at or after ptr, with wrap.
  always_comb begin
    gnt    = 1'b0;
    gnt_ch = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!gnt && iob_valid_i[(int'(ptr) + i) % N_CH]) begin
        gnt    = 1'b1;
        gnt_ch = PTR_W'((int'(ptr) + i) % N_CH);
      end
    end
    if (arst_i || blk_q) gnt = 1'b0;
  end

  assign addr_g  = iob_addr_i[gnt_ch*ADDR_W +: ADDR_W];
  assign wdata_g = iob_wdata_i[gnt_ch*DATA_W +: DATA_W];
  assign wstrb_g = iob_wstrb_i[gnt_ch*STRB_W +: STRB_W];
  assign gnt_rd  = gnt && (wstrb_g == '0);

  assign iob_ready_o = gnt ? (N_CH'(1) << gnt_ch) : '0;
  assign ram_en_o    = gnt;
  assign ram_we_o    = gnt ? wstrb_g : '0;
  assign ram_addr_o  = addr_g[ADDR_W-1:OFF_W];
  assign ram_d_o     = wdata_g;

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      ptr   <= '0;
      blk_q <= 1'b1;
      for (int s = 0; s < RAM_LAT; s++) begin
        tag_v[s]  <= 1'b0;
        tag_ch[s] <= '0;
      end
    end else begin
      blk_q <= 1'b0;
      if (gnt) ptr <= PTR_W'((int'(gnt_ch) + 1) % N_CH);
      tag_v[0]  <= gnt_rd;
      tag_ch[0] <= gnt_ch;
      for (int s = 1; s < RAM_LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_ch[s] <= tag_ch[s-1];
      end
    end
  end

  // The tag leaving the pipeline lines up with ram_d_i for that read.
  always_comb begin
    iob_rvalid_o = '0;
    iob_rdata_o  = '0;
    if (tag_v[RAM_LAT-1]) begin
      iob_rvalid_o[tag_ch[RAM_LAT-1]]                = 1'b1;
      iob_rdata_o[tag_ch[RAM_LAT-1]*DATA_W +: DATA_W] = ram_d_i;
    end
  end

endmodule
